// File: rtl/spi_controller_if.sv
// Request/response handshake and SPI pin bundle for spi_controller.
// master = controller side; slave = requester / peripheral side.
interface spi_controller_if #(
  parameter int COUNT_WIDTH = 16
);
  logic                   start_in;
  logic [7:0]             opcode_in;
  logic [COUNT_WIDTH-1:0] write_count_in;
  logic [COUNT_WIDTH-1:0] read_count_in;
  logic [7:0]             wr_data_in;
  logic                   wr_data_valid_in;
  logic                   wr_data_ready_out;
  logic [7:0]             rd_data_out;
  logic                   rd_data_valid_out;
  logic                   busy_out;
  logic                   done_out;
  logic                   spi_select_out;
  logic                   spi_clock_out;
  logic                   spi_data_out;
  logic                   spi_data_in;

  modport master (
    input  start_in, opcode_in, write_count_in, read_count_in,
           wr_data_in, wr_data_valid_in, spi_data_in,
    output wr_data_ready_out, rd_data_out, rd_data_valid_out, busy_out,
           done_out, spi_select_out, spi_clock_out, spi_data_out
  );

  modport slave (
    output start_in, opcode_in, write_count_in, read_count_in,
           wr_data_in, wr_data_valid_in, spi_data_in,
    input  wr_data_ready_out, rd_data_out, rd_data_valid_out, busy_out,
           done_out, spi_select_out, spi_clock_out, spi_data_out
  );
endinterface

// File: rtl/spi_controller.sv
// Mode-0 SPI initiator: CS low, opcode byte, then N write or M read bytes; SCLK = clock_in / (2*CLOCK_DIVIDER).
// Write bytes taken by valid/ready at byte boundaries; SPI_CONTROLLER_STALL_EN stalls on underflow, else 0x00 is sent.
module spi_controller #(
  parameter int CLOCK_DIVIDER = 2,
  parameter int COUNT_WIDTH   = 16
) (
  input  logic             clock_in,
  input  logic             reset_n_in,
  spi_controller_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, SETUP, OPCODE, WRITE, READ, HOLD, GAP
  } state_t;

  localparam logic [7:0]             HALF_LAST = 8'(CLOCK_DIVIDER - 1);
  localparam logic [COUNT_WIDTH-1:0] ONE       = COUNT_WIDTH'(1);

  state_t                 state;
  logic [7:0]             half_cnt;
  logic [2:0]             bit_cnt;
  logic [7:0]             tx_sr;
  logic [7:0]             rx_sr;
  logic [COUNT_WIDTH-1:0] wr_cnt;
  logic [COUNT_WIDTH-1:0] rd_cnt;
  logic                   rx_full;
  logic                   stalled;
  logic                   cs_q;
  logic                   sclk_q;
  logic                   mosi_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   rd_vld_q;
  logic [7:0]             rd_dat_q;

  logic half_end;
  logic byte_end;
  logic need_byte;

  assign half_end  = (half_cnt == HALF_LAST);
  assign byte_end  = half_end && sclk_q && (bit_cnt == 3'd7);
  // A write byte is due at the opcode's last falling edge and at every write boundary but the last.
  assign need_byte = byte_end &&
                     (((state == OPCODE) && (wr_cnt != '0)) ||
                      ((state == WRITE)  && (wr_cnt != ONE)));

`ifndef SPI_CONTROLLER_STALL_EN
  assign stalled = 1'b0;
`endif

  assign bus.wr_data_ready_out = bus.wr_data_valid_in && (need_byte || stalled);
  assign bus.spi_select_out    = cs_q;
  assign bus.spi_clock_out     = sclk_q;
  assign bus.spi_data_out      = mosi_q;
  assign bus.busy_out          = busy_q;
  assign bus.done_out          = done_q;
  assign bus.rd_data_valid_out = rd_vld_q;
  assign bus.rd_data_out       = rd_dat_q;

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state    <= IDLE;
      half_cnt <= '0;
      bit_cnt  <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      wr_cnt   <= '0;
      rd_cnt   <= '0;
      rx_full  <= 1'b0;
`ifdef SPI_CONTROLLER_STALL_EN
      stalled  <= 1'b0;
`endif
      cs_q     <= 1'b1;
      sclk_q   <= 1'b0;
      mosi_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rd_vld_q <= 1'b0;
      rd_dat_q <= '0;
    end else begin
      done_q   <= 1'b0;
      rd_vld_q <= 1'b0;
      if (rx_full) begin
        rx_full  <= 1'b0;
        rd_vld_q <= 1'b1;
        rd_dat_q <= rx_sr;
      end

      case (state)
        IDLE: begin
          if (bus.start_in) begin
            state    <= SETUP;
            busy_q   <= 1'b1;
            cs_q     <= 1'b0;
            tx_sr    <= bus.opcode_in;
            mosi_q   <= bus.opcode_in[7];
            wr_cnt   <= bus.write_count_in;
            rd_cnt   <= bus.read_count_in;
            half_cnt <= '0;
          end
        end

        SETUP: begin
          if (half_end) begin
            state    <= OPCODE;
            half_cnt <= '0;
            bit_cnt  <= '0;
          end else begin
            half_cnt <= half_cnt + 8'd1;
          end
        end

        OPCODE, WRITE, READ: begin
          if (stalled) begin
            // SCLK is parked low; the byte period restarts once data shows up.
            if (bus.wr_data_valid_in) begin
`ifdef SPI_CONTROLLER_STALL_EN
              stalled  <= 1'b0;
`endif
              tx_sr    <= bus.wr_data_in;
              mosi_q   <= bus.wr_data_in[7];
              half_cnt <= '0;
            end
          end else if (!half_end) begin
            half_cnt <= half_cnt + 8'd1;
          end else begin
            half_cnt <= '0;
            if (!sclk_q) begin
              sclk_q <= 1'b1;
              rx_sr  <= {rx_sr[6:0], bus.spi_data_in};
              if ((state == READ) && (bit_cnt == 3'd7)) begin
                rx_full <= 1'b1;
              end
            end else begin
              sclk_q  <= 1'b0;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt != 3'd7) begin
                tx_sr  <= {tx_sr[6:0], 1'b0};
                mosi_q <= tx_sr[6];
              end else begin
                if (state == WRITE) wr_cnt <= wr_cnt - ONE;
                if (state == READ)  rd_cnt <= rd_cnt - ONE;
                if (need_byte) begin
                  state <= WRITE;
                  if (bus.wr_data_valid_in) begin
                    tx_sr  <= bus.wr_data_in;
                    mosi_q <= bus.wr_data_in[7];
                  end else begin
`ifdef SPI_CONTROLLER_STALL_EN
                    stalled <= 1'b1;
`endif
                    tx_sr  <= '0;
                    mosi_q <= 1'b0;
                  end
                end else if (((state == OPCODE) && (rd_cnt != '0)) ||
                             ((state == READ) && (rd_cnt != ONE))) begin
                  state  <= READ;
                  tx_sr  <= '0;
                  mosi_q <= 1'b0;
                end else begin
                  state  <= HOLD;
                  tx_sr  <= '0;
                  mosi_q <= 1'b0;
                end
              end
            end
          end
        end

        HOLD: begin
          if (half_end) begin
            state    <= GAP;
            cs_q     <= 1'b1;
            done_q   <= 1'b1;
            half_cnt <= '0;
          end else begin
            half_cnt <= half_cnt + 8'd1;
          end
        end

        GAP: begin
          if (half_end) begin
            state    <= IDLE;
            busy_q   <= 1'b0;
            half_cnt <= '0;
          end else begin
            half_cnt <= half_cnt + 8'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_controller.sv
// Randomized self-checking bench for spi_controller with an in-bench SPI peripheral and data feeder.
module tb_spi_controller;
  localparam int H = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_controller_if #(.COUNT_WIDTH(16)) bus ();

  spi_controller #(.CLOCK_DIVIDER(H), .COUNT_WIDTH(16)) dut (
    .clock_in   (clk),
    .reset_n_in (rst_n),
    .bus        (bus)
  );

  int vectors = 0;
  int errors  = 0;

  int cyc = 0, cs_low = 0, rises = 0, fr_rise = 0, done_cnt = 0;
  int hs_cnt = 0, frames = 0, viol = 0, release_cyc = 0;
  logic       mosi_bits[$];
  logic [7:0] rd_q[$];
  logic [7:0] feed_q[$];
  logic [7:0] periph[$];
  bit         withhold = 1'b0;
  logic       prev_cs = 1'b1, prev_sclk = 1'b0;

  task automatic clear_stats();
    cs_low = 0; rises = 0; done_cnt = 0; hs_cnt = 0; frames = 0; viol = 0;
    mosi_bits.delete();
    rd_q.delete();
  endtask

  // Monitor, mode-0 peripheral and write-data feeder; outputs are sampled on the falling clock edge.
  initial begin : monitor
    logic [7:0] pb;
    int n;
    bus.spi_data_in      = 1'b0;
    bus.wr_data_valid_in = 1'b0;
    bus.wr_data_in       = 8'h00;
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.spi_select_out === 1'b0) cs_low++;
      if ((bus.spi_select_out !== prev_cs) && (bus.spi_clock_out || prev_sclk)) viol++;
      if (prev_cs && !bus.spi_select_out) fr_rise = 0;
      if (!prev_cs && bus.spi_select_out) frames++;
      if (bus.spi_clock_out && !prev_sclk) begin
        mosi_bits.push_back(bus.spi_data_out);
        rises++;
        fr_rise++;
      end
      if (bus.done_out) done_cnt++;
      if (bus.rd_data_valid_out) rd_q.push_back(bus.rd_data_out);
      prev_cs   = bus.spi_select_out;
      prev_sclk = bus.spi_clock_out;

      n = fr_rise - 8;
      if (!bus.spi_select_out && n >= 0 && (n / 8) < periph.size()) begin
        pb = periph[n / 8];
        bus.spi_data_in = pb[7 - (n % 8)];
      end else begin
        bus.spi_data_in = 1'b0;
      end

      if (feed_q.size() > 0 && cyc >= release_cyc) begin
        bus.wr_data_valid_in = 1'b1;
        bus.wr_data_in       = feed_q[0];
      end else begin
        bus.wr_data_valid_in = 1'b0;
        bus.wr_data_in       = 8'($urandom);
      end

      #1;
      if (bus.wr_data_ready_out && bus.wr_data_valid_in) begin
        hs_cnt++;
        void'(feed_q.pop_front());
        if (withhold && hs_cnt == 1) release_cyc = cyc + 16 * H + 20;
      end
    end
  end

  task automatic run_txn(input logic [7:0] op, input int wc, input int rc, output bit to);
    @(negedge clk); #3;
    clear_stats();
    @(negedge clk);
    bus.start_in       = 1'b1;
    bus.opcode_in      = op;
    bus.write_count_in = 16'(wc);
    bus.read_count_in  = 16'(rc);
    @(negedge clk);
    bus.start_in       = 1'b0;
    bus.opcode_in      = 8'($urandom);
    bus.write_count_in = 16'($urandom);
    bus.read_count_in  = 16'($urandom);
    to = 1'b1;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk); #3;
      if (!bus.busy_out) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #3;
    vectors++; if (bus.spi_select_out !== 1'b1) begin errors++; $display("FAIL reset_cs got %b want 1", bus.spi_select_out); end
    vectors++; if (bus.spi_clock_out !== 1'b0) begin errors++; $display("FAIL reset_sclk got %b want 0", bus.spi_clock_out); end
    vectors++; if (bus.spi_data_out !== 1'b0) begin errors++; $display("FAIL reset_mosi got %b want 0", bus.spi_data_out); end
    vectors++; if (bus.busy_out !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy_out); end
    vectors++; if (bus.done_out !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done_out); end
    vectors++; if (bus.rd_data_valid_out !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %b want 0", bus.rd_data_valid_out); end
    vectors++; if (bus.rd_data_out !== 8'h00) begin errors++; $display("FAIL reset_rd_data got %02h want 00", bus.rd_data_out); end
    vectors++; if (bus.wr_data_ready_out !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", bus.wr_data_ready_out); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #3;
    vectors++; if (bus.spi_select_out !== 1'b1 || bus.busy_out !== 1'b0) begin
      errors++; $display("FAIL post_reset_idle got cs=%b busy=%b want cs=1 busy=0", bus.spi_select_out, bus.busy_out);
    end
  endtask

  task automatic test_opcode_only();
    logic [7:0] got;
    bit to;
    run_txn(8'hDB, 0, 0, to);
    got = 8'h00;
    for (int k = 0; k < 8 && k < mosi_bits.size(); k++) got = {got[6:0], mosi_bits[k]};
    vectors++; if (to) begin errors++; $display("FAIL opc_timeout busy still 1 want 0"); end
    vectors++; if (cs_low !== H + 16 * H + H) begin errors++; $display("FAIL opc_cs_len got %0d want %0d", cs_low, H + 16 * H + H); end
    vectors++; if (rises !== 8) begin errors++; $display("FAIL opc_rises got %0d want 8", rises); end
    vectors++; if (got !== 8'hDB) begin errors++; $display("FAIL opc_mosi got %02h want db", got); end
    vectors++; if (done_cnt !== 1) begin errors++; $display("FAIL opc_done got %0d want 1", done_cnt); end
    vectors++; if (hs_cnt !== 0 || rd_q.size() !== 0) begin errors++; $display("FAIL opc_no_data got hs=%0d rd=%0d want 0 0", hs_cnt, rd_q.size()); end
    vectors++; if (viol !== 0) begin errors++; $display("FAIL opc_sclk_at_cs got %0d want 0", viol); end
  endtask

  task automatic test_write();
    logic [7:0] op, got;
    logic [7:0] exp[$];
    int n, len;
    bit to;
    for (int it = 0; it < 3; it++) begin
      exp.delete();
      feed_q.delete();
      if (it == 0) begin
        op = 8'h12; n = 3;
        exp = '{8'h12, 8'hA5, 8'h3C, 8'hFF};
      end else begin
        op = 8'($urandom); n = $urandom_range(1, 4);
        exp.push_back(op);
        for (int i = 0; i < n; i++) exp.push_back(8'($urandom));
      end
      for (int i = 1; i < exp.size(); i++) feed_q.push_back(exp[i]);
      // A non-zero read count alongside writes must be ignored.
      run_txn(op, n, (it == 0) ? 0 : $urandom_range(1, 5), to);
      feed_q.delete();
      len = H + 16 * H * (n + 1) + H;
      vectors++; if (to) begin errors++; $display("FAIL wr_timeout it=%0d busy still 1 want 0", it); end
      vectors++; if (rises !== 8 * (n + 1)) begin errors++; $display("FAIL wr_rises it=%0d got %0d want %0d", it, rises, 8 * (n + 1)); end
      vectors++; if (hs_cnt !== n) begin errors++; $display("FAIL wr_handshakes it=%0d got %0d want %0d", it, hs_cnt, n); end
      vectors++; if (cs_low !== len) begin errors++; $display("FAIL wr_cs_len it=%0d got %0d want %0d", it, cs_low, len); end
      vectors++; if (done_cnt !== 1 || rd_q.size() !== 0) begin errors++; $display("FAIL wr_done_rd it=%0d got done=%0d rd=%0d want 1 0", it, done_cnt, rd_q.size()); end
      vectors++; if (viol !== 0) begin errors++; $display("FAIL wr_sclk_at_cs it=%0d got %0d want 0", it, viol); end
      for (int b = 0; b < exp.size(); b++) begin
        got = 8'h00;
        for (int k = 0; k < 8; k++) if (8 * b + k < mosi_bits.size()) got = {got[6:0], mosi_bits[8 * b + k]};
        vectors++; if (got !== exp[b]) begin errors++; $display("FAIL wr_mosi it=%0d byte=%0d got %02h want %02h", it, b, got, exp[b]); end
      end
    end
  endtask

  task automatic test_read();
    logic [7:0] op, got;
    int n;
    bit to;
    for (int it = 0; it < 3; it++) begin
      periph.delete();
      if (it == 0) begin
        op = 8'hDB; n = 2;
        periph = '{8'h81, 8'h7E};
      end else begin
        op = 8'($urandom); n = $urandom_range(1, 3);
        for (int i = 0; i < n; i++) periph.push_back(8'($urandom));
      end
      run_txn(op, 0, n, to);
      vectors++; if (to) begin errors++; $display("FAIL rd_timeout it=%0d busy still 1 want 0", it); end
      vectors++; if (rd_q.size() !== n) begin errors++; $display("FAIL rd_count it=%0d got %0d want %0d", it, rd_q.size(), n); end
      for (int i = 0; i < n && i < rd_q.size(); i++) begin
        vectors++; if (rd_q[i] !== periph[i]) begin errors++; $display("FAIL rd_data it=%0d byte=%0d got %02h want %02h", it, i, rd_q[i], periph[i]); end
      end
      vectors++; if (cs_low !== H + 16 * H * (n + 1) + H) begin errors++; $display("FAIL rd_cs_len it=%0d got %0d want %0d", it, cs_low, H + 16 * H * (n + 1) + H); end
      vectors++; if (done_cnt !== 1 || hs_cnt !== 0) begin errors++; $display("FAIL rd_done_hs it=%0d got done=%0d hs=%0d want 1 0", it, done_cnt, hs_cnt); end
      for (int b = 0; b <= n; b++) begin
        got = 8'h00;
        for (int k = 0; k < 8; k++) if (8 * b + k < mosi_bits.size()) got = {got[6:0], mosi_bits[8 * b + k]};
        vectors++; if (got !== ((b == 0) ? op : 8'h00)) begin
          errors++; $display("FAIL rd_mosi it=%0d byte=%0d got %02h want %02h", it, b, got, (b == 0) ? op : 8'h00);
        end
      end
    end
    periph.delete();
  endtask

  task automatic test_underflow();
    logic [7:0] op, b0, got;
    logic [7:0] exp[$];
    int len, hs_exp;
    bit to;
    op = 8'($urandom);
    b0 = 8'($urandom);
    feed_q = '{b0, 8'h55};
    withhold = 1'b1;
    run_txn(op, 2, 0, to);
    withhold = 1'b0;
    release_cyc = 0;
    feed_q.delete();
`ifdef SPI_CONTROLLER_STALL_EN
    exp = '{op, b0, 8'h55};
    len = H + 16 * H * 3 + H + 20;
    hs_exp = 2;
`else
    exp = '{op, b0, 8'h00};
    len = H + 16 * H * 3 + H;
    hs_exp = 1;
`endif
    vectors++; if (to) begin errors++; $display("FAIL uf_timeout busy still 1 want 0"); end
    vectors++; if (cs_low !== len) begin errors++; $display("FAIL uf_cs_len got %0d want %0d", cs_low, len); end
    vectors++; if (hs_cnt !== hs_exp) begin errors++; $display("FAIL uf_handshakes got %0d want %0d", hs_cnt, hs_exp); end
    vectors++; if (rises !== 24 || done_cnt !== 1) begin errors++; $display("FAIL uf_rises_done got %0d/%0d want 24/1", rises, done_cnt); end
    for (int b = 0; b < 3; b++) begin
      got = 8'h00;
      for (int k = 0; k < 8; k++) if (8 * b + k < mosi_bits.size()) got = {got[6:0], mosi_bits[8 * b + k]};
      vectors++; if (got !== exp[b]) begin errors++; $display("FAIL uf_mosi byte=%0d got %02h want %02h", b, got, exp[b]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] got, op;
    bit to;
    op = 8'($urandom);
    @(negedge clk); #3;
    clear_stats();
    @(negedge clk);
    bus.start_in = 1'b1; bus.opcode_in = op; bus.write_count_in = 16'd0; bus.read_count_in = 16'd0;
    @(negedge clk);
    bus.start_in = 1'b0;
    for (int i = 0; i < 500 && rises < 4; i++) begin @(negedge clk); #3; end
    vectors++; if (rises !== 4) begin errors++; $display("FAIL rst_mid_reach got rises=%0d want 4", rises); end
    rst_n = 1'b0;
    #1;
    vectors++; if ({bus.spi_select_out, bus.spi_clock_out, bus.spi_data_out, bus.busy_out} !== 4'b1000) begin
      errors++; $display("FAIL rst_mid_outputs got cs,sclk,mosi,busy=%b want 1000",
                         {bus.spi_select_out, bus.spi_clock_out, bus.spi_data_out, bus.busy_out});
    end
    repeat (4) @(negedge clk);
    #3;
    vectors++; if (done_cnt !== 0) begin errors++; $display("FAIL rst_mid_no_done got %0d want 0", done_cnt); end
    rst_n = 1'b1;
    run_txn(op, 0, 0, to);
    got = 8'h00;
    for (int k = 0; k < 8 && k < mosi_bits.size(); k++) got = {got[6:0], mosi_bits[k]};
    vectors++; if (to || done_cnt !== 1) begin errors++; $display("FAIL rst_mid_recover got timeout=%0d done=%0d want 0 1", to, done_cnt); end
    vectors++; if (cs_low !== H + 16 * H + H || got !== op) begin
      errors++; $display("FAIL rst_mid_frame got len=%0d mosi=%02h want %0d %02h", cs_low, got, H + 16 * H + H, op);
    end
  endtask

  task automatic test_start_while_busy();
    logic [7:0] op, got;
    bit to;
    op = 8'($urandom);
    fork
      run_txn(op, 0, 0, to);
      begin
        repeat (15) @(negedge clk);
        bus.start_in = 1'b1;
        bus.opcode_in = ~op;
        @(negedge clk);
        bus.start_in = 1'b0;
      end
    join
    repeat (10) @(negedge clk);
    #3;
    got = 8'h00;
    for (int k = 0; k < 8 && k < mosi_bits.size(); k++) got = {got[6:0], mosi_bits[k]};
    vectors++; if (to) begin errors++; $display("FAIL busy_start_timeout busy still 1 want 0"); end
    vectors++; if (frames !== 1 || done_cnt !== 1) begin errors++; $display("FAIL busy_start_frames got frames=%0d done=%0d want 1 1", frames, done_cnt); end
    vectors++; if (got !== op || rises !== 8) begin errors++; $display("FAIL busy_start_mosi got %02h/%0d want %02h/8", got, rises, op); end
    vectors++; if (bus.busy_out !== 1'b0) begin errors++; $display("FAIL busy_start_idle got busy=%b want 0", bus.busy_out); end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start_in       = 1'b0;
    bus.opcode_in      = 8'h00;
    bus.write_count_in = 16'd0;
    bus.read_count_in  = 16'd0;
    test_reset();
    test_opcode_only();
    test_write();
    test_read();
    test_underflow();
    test_reset_mid();
    test_start_while_busy();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/spi_controller.md
# spi_controller

SPI controller (initiator) that issues opcode/operand transactions in the same framing our FPGA SPI peripheral decodes: CS low, one opcode byte, then N write operand bytes or M read operand bytes, CS high. Mode 0 (CPOL=0, CPHA=0), MSB first. Used as the self-check driver in loopback builds, and as the master for on-board SPI peripherals. All logic sits in one system clock domain, and SCLK is generated by division from that clock.

## Interface
Parameters:
- `CLOCK_DIVIDER`, 2: SCLK half-period in `clock_in` cycles; legal range 1..255.
- `COUNT_WIDTH`, 16: width of the byte-count inputs.

Ports:
- `clock_in` input 1: system clock. The block has one clock.
- `reset_n_in` input 1: reset, asynchronous and active-low.
- `start_in` input 1: single-cycle request. Ignored while `busy_out`=1.
- `opcode_in` input 8: opcode byte. Captured on an accepted `start_in`.
- `write_count_in` input COUNT_WIDTH: number of operand bytes to send. Captured on start.
- `read_count_in` input COUNT_WIDTH: number of operand bytes to receive. Captured on start. Used only when `write_count_in`=0.
- `wr_data_in` input 8: next write operand byte.
- `wr_data_valid_in` input 1: `wr_data_in` is valid.
- `wr_data_ready_out` output 1: byte consumed this cycle. Valid/ready handshake.
- `rd_data_out` output 8: received operand byte.
- `rd_data_valid_out` output 1: one-cycle strobe with `rd_data_out`.
- `busy_out` output 1: a transaction is in progress.
- `done_out` output 1: one-cycle strobe when CS deasserts.
- `spi_select_out` output 1: chip select, active low.
- `spi_clock_out` output 1: SCLK, idles low.
- `spi_data_out` output 1: MOSI.
- `spi_data_in` input 1: MISO.

## Operation
- Reset values: `spi_select_out`=1, `spi_clock_out`=0, `spi_data_out`=0. All strobes are 0. `busy_out`=0. `rd_data_out`=0x00.
- States:
  - IDLE: on `start_in`, latch opcode and counts, set busy, go to SETUP.
  - SETUP: CS low; MSB of the opcode is driven; wait one half-period; go to OPCODE.
  - OPCODE: shift 8 bits.
  - Exit from OPCODE:
    - write_count>0: go to WRITE.
    - write_count=0 and read_count>0: go to READ.
    - otherwise: go to HOLD.
  - WRITE: the byte is taken via handshake at each byte boundary (`wr_data_ready_out`=1 for the cycle the byte is latched), then shifted. Decrement the count; at 0 go to HOLD.
  - READ: MOSI is driven 0. Shift in 8 bits, then pulse `rd_data_valid_out` with the byte. Decrement the count; at 0 go to HOLD.
  - HOLD: SCLK low for one half-period with CS still low; go to GAP.
  - GAP: CS high for at least one half-period, `done_out` pulses on entry, `busy_out` clears at exit; go to IDLE.
- Write and read are mutually exclusive, matching the peripheral's framing. The read count is ignored when the write count is non-zero.
- Bit engine:
  - SCLK rises at the end of the first half-period of each bit, and MISO is sampled on that edge.
  - SCLK falls at the end of the second half-period, and MOSI advances to the next bit on that falling edge.
  - The last falling edge of a byte coincides with the byte boundary.
- Write underflow (`wr_data_valid_in`=0 at a byte boundary): behaviour is set by the Configuration section.
- `start_in` while busy is dropped. No queueing.
- Asynchronous reset mid-transaction forces the reset values immediately; no `done_out` is generated.

## Timing
- Half-period H = `CLOCK_DIVIDER` system cycles.
- Bit time = 2H.
- Transaction length with no stalls: H (setup) + 16H × (1 + bytes) + H (hold) + H (gap).
- Start-to-CS-low latency: 1 cycle after the accepted `start_in`.
- `rd_data_valid_out` asserts 1 cycle after the 8th rising edge of the byte.
- `wr_data_ready_out` asserts no later than the last falling edge of the previous byte. For the first write byte, it asserts at the last falling edge of the opcode.
- SCLK and the counters are registered, so the outputs are glitch-free. SCLK is never high when CS transitions.
- Counts use full COUNT_WIDTH arithmetic. The maximum is 2^COUNT_WIDTH−1 bytes, with no wrap.

## Configuration
- Macro: `SPI_CONTROLLER_STALL_EN`.
- Defined: on write underflow, SCLK is held low, CS stays low, and the state is held until `wr_data_valid_in`=1. The byte is then consumed and shifting resumes H cycles later.
- Undefined: the write never stalls. On underflow, 0x00 is sent in place of the byte, `wr_data_ready_out` stays 0, and the count still decrements.

## Test plan
- Opcode-only:
  - Stimulus: opcode 0xDB, counts 0/0, divider 2.
  - Required: CS low for exactly H + 32 + H cycles; MOSI 11011011 on the 8 rising edges; `done_out` once.
- Write 3 bytes:
  - Stimulus: opcode 0x12, bytes 0xA5/0x3C/0xFF with valid held high.
  - Required: 32 SCLK pulses; MOSI matches MSB-first; exactly 3 ready handshakes.
- Read 2 bytes:
  - Stimulus: opcode 0xDB, read_count 2; bench peripheral drives 0x81 then 0x7E.
  - Required: `rd_data_valid_out` twice, with values 0x81 then 0x7E.
- Underflow:
  - Stimulus: write_count 2; the second byte is withheld 20 cycles.
  - Required with `SPI_CONTROLLER_STALL_EN`: SCLK low for 20 extra cycles, then 0x55 is sent correctly.
  - Required without it: 0x00 is sent and the total length is unchanged.
- Reset mid-byte:
  - Stimulus: assert `reset_n_in` low during the 4th bit of the opcode.
  - Required: the same cycle shows CS=1, SCLK=0, MOSI=0, busy=0, and no `done_out`; the next start completes normally.
- Start while busy:
  - Stimulus: a second `start_in` mid-transaction.
  - Required: it is ignored; exactly one CS frame and one `done_out`.
